// File: rtl/ldst_sequencer.sv
// Single-outstanding load/store sequencer: aligns, lane-maps and issues one bus
// access at a time, then reports completion, misalignment or bus timeout.
module ldst_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_start,
  input  logic [2:0]  in_ldst_type,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_fault,
  output logic [31:0] out_load_data,
  output logic        out_mem_req,
  output logic [31:0] out_mem_addr,
  output logic        out_mem_we,
  output logic [3:0]  out_mem_byte_en,
  output logic [31:0] out_mem_wdata,
  input  logic        in_mem_ack,
  input  logic [31:0] in_mem_rdata
);

  localparam logic [2:0] LD32  = 3'd0;
  localparam logic [2:0] LDU16 = 3'd1;
  localparam logic [2:0] LDS16 = 3'd2;
  localparam logic [2:0] LDU8  = 3'd3;
  localparam logic [2:0] LDS8  = 3'd4;
  localparam logic [2:0] ST32  = 3'd5;
  localparam logic [2:0] ST16  = 3'd6;
  localparam logic [2:0] ST8   = 3'd7;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        r_state;
  logic [2:0]    r_type;
  logic [1:0]    r_addr_lo;
  logic [CW-1:0] r_cnt;

  logic          w_is32;
  logic          w_is16;
  logic          w_is_store;
  logic          w_aligned;
  logic [3:0]    w_byte_en;
  logic [31:0]   w_wdata;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load;
  logic          w_limit;

  // Decode of the request presented on the start interface.
  always_comb begin
    w_is32     = (in_ldst_type == LD32) || (in_ldst_type == ST32);
    w_is16     = (in_ldst_type == LDU16) || (in_ldst_type == LDS16) || (in_ldst_type == ST16);
    w_is_store = (in_ldst_type == ST32) || (in_ldst_type == ST16) || (in_ldst_type == ST8);
    w_aligned  = w_is32 ? (in_addr[1:0] == 2'b00) :
                 w_is16 ? (in_addr[0] == 1'b0) : 1'b1;
    if (w_is32)      w_byte_en = 4'b1111;
    else if (w_is16) w_byte_en = in_addr[1] ? 4'b1100 : 4'b0011;
    else             w_byte_en = 4'b0001 << in_addr[1:0];
    case (in_ldst_type)
      ST32:    w_wdata = in_store_data;
      ST16:    w_wdata = {2{in_store_data[15:0]}};
      ST8:     w_wdata = {4{in_store_data[7:0]}};
      default: w_wdata = 32'd0;
    endcase
  end

  // Accesses are naturally aligned, so one byte-granular shift brings the
  // addressed lane(s) down to bit 0 for every load width.
  always_comb begin
    w_shifted = in_mem_rdata >> {r_addr_lo, 3'b000};
    case (r_type)
      LD32:    w_load = in_mem_rdata;
      LDU16:   w_load = {16'd0, w_shifted[15:0]};
      LDS16:   w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LDU8:    w_load = {24'd0, w_shifted[7:0]};
      LDS8:    w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      default: w_load = 32'd0;
    endcase
  end

  assign w_limit = (TIMEOUT_CYCLES != 0) && ((32'(r_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_type          <= LD32;
      r_addr_lo       <= 2'b00;
      r_cnt           <= '0;
      out_busy        <= 1'b0;
      out_done        <= 1'b0;
      out_fault       <= 1'b0;
      out_load_data   <= 32'd0;
      out_mem_req     <= 1'b0;
      out_mem_addr    <= 32'd0;
      out_mem_we      <= 1'b0;
      out_mem_byte_en <= 4'b0000;
      out_mem_wdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          out_done  <= 1'b0;
          out_fault <= 1'b0;
          if (in_start) begin
            out_busy      <= 1'b1;
            out_load_data <= 32'd0;
            if (w_aligned) begin
              r_state         <= S_REQ;
              r_type          <= in_ldst_type;
              r_addr_lo       <= in_addr[1:0];
              r_cnt           <= '0;
              out_mem_req     <= 1'b1;
              out_mem_addr    <= {in_addr[31:2], 2'b00};
              out_mem_we      <= w_is_store;
              out_mem_byte_en <= w_byte_en;
              out_mem_wdata   <= w_wdata;
            end else begin
              // Misaligned: report immediately, the bus is never touched.
              r_state   <= S_FAULT;
              out_done  <= 1'b1;
              out_fault <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (in_mem_ack) begin
            r_state       <= S_DONE;
            out_mem_req   <= 1'b0;
            out_done      <= 1'b1;
            out_fault     <= 1'b0;
            out_load_data <= w_load;
          end else if (w_limit) begin
            r_state       <= S_FAULT;
            out_mem_req   <= 1'b0;
            out_done      <= 1'b1;
            out_fault     <= 1'b1;
            out_load_data <= 32'd0;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE, S_FAULT: begin
          r_state       <= S_IDLE;
          out_busy      <= 1'b0;
          out_done      <= 1'b0;
          out_fault     <= 1'b0;
          out_load_data <= 32'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
